// File: rtl/commit_freelist_rat.sv
// Commit-side register alias table and circular free-tag list: records committed mappings,
// recycles overwritten tags, offers tags to rename, and rewinds allocation on a full flush.
module commit_freelist_rat #(
  parameter int WIDTH    = 2,
  parameter int TAG_W    = 6,
  parameter int NAME_W   = 5,
  parameter int FL_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        IN_comValid,
  input  logic [WIDTH*NAME_W-1:0] IN_comNames,
  input  logic [WIDTH*TAG_W-1:0]  IN_comTags,
  input  logic                    IN_flush,
  input  logic [WIDTH-1:0]        IN_allocReq,
  output logic [WIDTH*TAG_W-1:0]  OUT_allocTags,
  output logic                    OUT_allocValid,
  input  logic                    IN_rdEn,
  input  logic [NAME_W-1:0]       IN_rdName,
  output logic [TAG_W-1:0]        OUT_rdTag,
  output logic                    OUT_rdValid,
  output logic [TAG_W-1:0]        OUT_freeCount
);

  localparam int PTR_W = $clog2(FL_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam int NREG  = 2 ** NAME_W;

  logic [TAG_W-1:0] rat_r [NREG];
  logic [TAG_W-1:0] fl_r  [FL_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] com_rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [TAG_W-1:0] rd_tag_r;
  logic             rd_valid_r;

  logic [TAG_W-1:0]       rat_next_s [NREG];
  logic [WIDTH-1:0]       push_en_s;
  logic [IDX_W-1:0]       push_idx_s [WIDTH];
  logic [TAG_W-1:0]       push_tag_s [WIDTH];
  logic [PTR_W-1:0]       push_cnt_s;
  logic [PTR_W-1:0]       req_cnt_s;
  logic [WIDTH*TAG_W-1:0] alloc_tags_s;
  logic                   alloc_valid_s;
  logic [TAG_W-1:0]       free_count_s;

  assign free_count_s   = TAG_W'(wr_ptr_r - rd_ptr_r);
  assign alloc_valid_s  = (free_count_s >= TAG_W'(req_cnt_s)) && !IN_flush;
  assign OUT_allocTags  = alloc_tags_s;
  assign OUT_allocValid = alloc_valid_s;
  assign OUT_rdTag      = rd_tag_r;
  assign OUT_rdValid    = rd_valid_r;
  assign OUT_freeCount  = free_count_s;

  // Offer consecutive free-list entries to requesting lanes in lane order.
  always_comb begin
    req_cnt_s    = '0;
    alloc_tags_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (IN_allocReq[i]) begin
        alloc_tags_s[i*TAG_W +: TAG_W] = fl_r[IDX_W'(rd_ptr_r + req_cnt_s)];
        req_cnt_s = req_cnt_s + PTR_W'(1);
      end else begin
        alloc_tags_s[i*TAG_W +: TAG_W] = '0;
      end
    end
  end

  // Apply commits in lane order; a lower lane's update is visible to higher lanes.
  always_comb begin
    rat_next_s = rat_r;
    push_cnt_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (IN_comValid[i] && (IN_comNames[i*NAME_W +: NAME_W] != NAME_W'(0))) begin
        push_en_s[i]  = 1'b1;
        push_idx_s[i] = IDX_W'(wr_ptr_r + push_cnt_s);
        push_tag_s[i] = rat_next_s[IN_comNames[i*NAME_W +: NAME_W]];
        rat_next_s[IN_comNames[i*NAME_W +: NAME_W]] = IN_comTags[i*TAG_W +: TAG_W];
        push_cnt_s    = push_cnt_s + PTR_W'(1);
      end else begin
        push_en_s[i]  = 1'b0;
        push_idx_s[i] = '0;
        push_tag_s[i] = '0;
      end
    end
  end

  // State update; a flush rewinds the allocation pointer to the post-commit point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREG; k++) rat_r[k] <= TAG_W'(k);
      for (int k = 0; k < FL_DEPTH; k++) fl_r[k] <= TAG_W'(NREG + k);
      rd_ptr_r     <= '0;
      com_rd_ptr_r <= '0;
      wr_ptr_r     <= PTR_W'(FL_DEPTH);
      rd_tag_r     <= '0;
      rd_valid_r   <= 1'b0;
    end else begin
      rat_r <= rat_next_s;
      for (int i = 0; i < WIDTH; i++) begin
        if (push_en_s[i]) fl_r[push_idx_s[i]] <= push_tag_s[i];
      end
      wr_ptr_r     <= wr_ptr_r + push_cnt_s;
      com_rd_ptr_r <= com_rd_ptr_r + push_cnt_s;
      if (IN_flush) begin
        rd_ptr_r <= com_rd_ptr_r + push_cnt_s;
      end else if (alloc_valid_s) begin
        rd_ptr_r <= rd_ptr_r + req_cnt_s;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      rd_valid_r <= IN_rdEn;
      if (IN_rdEn) begin
        rd_tag_r <= rat_next_s[IN_rdName];
      end else begin
        rd_tag_r <= rd_tag_r;
      end
    end
  end

  // Tag conservation bounds the number of free entries.
  free_count_bound: assert property (@(posedge clk) disable iff (!rst)
    free_count_s <= TAG_W'(FL_DEPTH));

endmodule

// File: tb/tb_commit_freelist_rat.sv
// Randomized bench for commit_freelist_rat: a queue-based model of free tags, uncommitted
// allocations and the committed map, plus directed literal scenarios and a mid-run reset.
module tb_commit_freelist_rat;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  com_valid;
  logic [9:0]  com_names;
  logic [11:0] com_tags;
  logic        flush;
  logic [1:0]  alloc_req;
  logic [11:0] alloc_tags;
  logic        alloc_valid;
  logic        rd_en;
  logic [4:0]  rd_name;
  logic [5:0]  rd_tag;
  logic        rd_valid;
  logic [5:0]  free_count;

  int errors = 0;
  int checks = 0;

  int rat_m [32];
  int fl_q[$];
  int spec_q[$];
  int exp_rd_tag;
  int exp_rd_valid;
  int inf_name[$];
  int inf_tag[$];

  always #5 clk = ~clk;

  commit_freelist_rat dut (
    .clk(clk), .rst(rst),
    .IN_comValid(com_valid), .IN_comNames(com_names), .IN_comTags(com_tags),
    .IN_flush(flush), .IN_allocReq(alloc_req),
    .OUT_allocTags(alloc_tags), .OUT_allocValid(alloc_valid),
    .IN_rdEn(rd_en), .IN_rdName(rd_name),
    .OUT_rdTag(rd_tag), .OUT_rdValid(rd_valid), .OUT_freeCount(free_count)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rat_m[i] = i;
    fl_q.delete();
    spec_q.delete();
    for (int k = 0; k < 32; k++) fl_q.push_back(32 + k);
    exp_rd_tag   = 0;
    exp_rd_valid = 0;
    inf_name.delete();
    inf_tag.delete();
  endtask

  task automatic drop(input int n);
    for (int i = 0; i < n; i++) begin
      void'(inf_name.pop_front());
      void'(inf_tag.pop_front());
    end
  endtask

  // Drive one cycle from a negedge, compare against the model, advance the model.
  task automatic step(input logic [1:0] cv, input logic [9:0] cn, input logic [11:0] ct,
                      input logic fl, input logic [1:0] req, input logic [9:0] rn,
                      input logic rde, input logic [4:0] rdn);
    int n;
    int j;
    int nm;
    int t;
    int ev;
    com_valid = cv; com_names = cn; com_tags = ct; flush = fl;
    alloc_req = req; rd_en = rde; rd_name = rdn;
    #1;
    n  = int'(req[0]) + int'(req[1]);
    ev = ((fl_q.size() >= n) && !fl) ? 1 : 0;
    chk("free_count", int'(free_count), fl_q.size());
    chk("alloc_valid", int'(alloc_valid), ev);
    chk("rd_valid", int'(rd_valid), exp_rd_valid);
    chk("rd_tag", int'(rd_tag), exp_rd_tag);
    j = 0;
    for (int i = 0; i < 2; i++) begin
      if (req[i]) begin
        if (j < fl_q.size()) chk("alloc_tag", int'(alloc_tags[i*6 +: 6]), fl_q[j]);
        j++;
      end else begin
        chk("alloc_tag_idle", int'(alloc_tags[i*6 +: 6]), 0);
      end
    end
    if (ev != 0) begin
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          t = fl_q.pop_front();
          spec_q.push_back(t);
          inf_name.push_back(int'(rn[i*5 +: 5]));
          inf_tag.push_back(t);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      nm = int'(cn[i*5 +: 5]);
      if (cv[i] && nm != 0) begin
        fl_q.push_back(rat_m[nm]);
        rat_m[nm] = int'(ct[i*6 +: 6]);
        if (spec_q.size() > 0) void'(spec_q.pop_front());
      end
    end
    if (fl) begin
      while (spec_q.size() > 0) fl_q.push_front(spec_q.pop_back());
    end
    exp_rd_valid = int'(rde);
    if (rde) exp_rd_tag = rat_m[rdn];
    @(negedge clk);
  endtask

  // Random cycle honouring the in-order allocate/commit contract.
  task automatic rand_cycle();
    logic [1:0]  cv;
    logic [9:0]  cn;
    logic [11:0] ct;
    logic        fl;
    logic [1:0]  req;
    logic [9:0]  rn;
    int k;
    int lane;
    cv = 2'b00;
    cn = 10'($urandom);
    ct = 12'($urandom);
    fl = ($urandom_range(0, 19) == 0);
    k  = $urandom_range(0, 2);
    if (k > inf_name.size()) k = inf_name.size();
    if (k == 1) begin
      lane = $urandom_range(0, 1);
      cv[lane] = 1'b1;
      cn[lane*5 +: 5] = 5'(inf_name.pop_front());
      ct[lane*6 +: 6] = 6'(inf_tag.pop_front());
      if (fl && $urandom_range(0, 1) == 1) cn[lane*5 +: 5] = 5'd0;
    end else if (k == 2) begin
      cv = 2'b11;
      for (int i = 0; i < 2; i++) begin
        cn[i*5 +: 5] = 5'(inf_name.pop_front());
        ct[i*6 +: 6] = 6'(inf_tag.pop_front());
      end
    end else if ($urandom_range(0, 3) == 0) begin
      cv[0] = 1'b1;
      cn[4:0] = 5'd0;
    end
    for (int i = 0; i < 2; i++) begin
      req[i] = ($urandom_range(0, 3) != 0);
      rn[i*5 +: 5] = 5'($urandom_range(1, 31));
    end
    step(cv, cn, ct, fl, req, rn, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    if (fl) begin
      inf_name.delete();
      inf_tag.delete();
    end
  endtask

  initial begin
    rst = 1'b0;
    com_valid = 2'b00; com_names = 10'd0; com_tags = 12'd0; flush = 1'b0;
    alloc_req = 2'b00; rd_en = 1'b0; rd_name = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_free", int'(free_count), 32);
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_tag", int'(rd_tag), 0);

    alloc_req = 2'b11;
    #1;
    chk("t1_tag0", int'(alloc_tags[5:0]), 32);
    chk("t1_tag1", int'(alloc_tags[11:6]), 33);
    chk("t1_valid", int'(alloc_valid), 1);
    step(2'b00, 10'd0, 12'd0, 1'b0, 2'b11, {5'd7, 5'd5}, 1'b0, 5'd0);
    chk("t1_free", int'(free_count), 30);

    repeat (15) step(2'b00, 10'd0, 12'd0, 1'b0, 2'b11, {5'd7, 5'd7}, 1'b0, 5'd0);
    chk("t2_free", int'(free_count), 0);
    alloc_req = 2'b01;
    #1;
    chk("t2_valid", int'(alloc_valid), 0);
    step(2'b00, 10'd0, 12'd0, 1'b0, 2'b01, {5'd7, 5'd7}, 1'b0, 5'd0);
    chk("t2_hold", int'(free_count), 0);

    step(2'b01, {5'd0, 5'd5}, {6'd0, 6'd32}, 1'b0, 2'b00, 10'd0, 1'b1, 5'd5);
    drop(1);
    chk("t3_free", int'(free_count), 1);
    chk("t3_rd", int'(rd_tag), 32);
    alloc_req = 2'b01;
    #1;
    chk("t3_offer", int'(alloc_tags[5:0]), 5);

    step(2'b11, {5'd7, 5'd7}, {6'd34, 6'd33}, 1'b0, 2'b00, 10'd0, 1'b1, 5'd7);
    drop(2);
    chk("t4_free", int'(free_count), 3);
    chk("t4_rd", int'(rd_tag), 34);
    alloc_req = 2'b11;
    #1;
    chk("t4_offer0", int'(alloc_tags[5:0]), 5);
    chk("t4_offer1", int'(alloc_tags[11:6]), 7);
    step(2'b00, 10'd0, 12'd0, 1'b0, 2'b11, {5'd9, 5'd3}, 1'b0, 5'd0);

    step(2'b00, 10'd0, 12'd0, 1'b1, 2'b00, 10'd0, 1'b0, 5'd0);
    inf_name.delete();
    inf_tag.delete();
    chk("t5_free", int'(free_count), 32);
    alloc_req = 2'b11;
    #1;
    chk("t5_offer0", int'(alloc_tags[5:0]), 35);
    chk("t5_offer1", int'(alloc_tags[11:6]), 36);

    step(2'b01, {5'd0, 5'd0}, {6'd0, 6'd9}, 1'b0, 2'b00, 10'd0, 1'b1, 5'd0);
    chk("t6_free", int'(free_count), 32);
    chk("t6_rd", int'(rd_tag), 0);

    repeat (1500) rand_cycle();

    #2;
    rst = 1'b0;
    com_valid = 2'b00; flush = 1'b0; rd_en = 1'b0; alloc_req = 2'b11;
    #1;
    chk("midrst_free", int'(free_count), 32);
    chk("midrst_rd_valid", int'(rd_valid), 0);
    chk("midrst_rd_tag", int'(rd_tag), 0);
    chk("midrst_tag0", int'(alloc_tags[5:0]), 32);
    chk("midrst_tag1", int'(alloc_tags[11:6]), 33);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    repeat (500) rand_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
